// File: rtl/alu_pipe_if.sv
// alu_pipe_if: command/result bundle for alu_pipe.
//   Issue side  : IN_VALID/IN_READY handshake carrying MODE, CMD, OPV, OPA, OPB,
//                 CIN and IN_TAG.
//   Result side : OUT_VALID/OUT_READY handshake carrying OUT_TAG, RES, MUL_RES
//                 and the COUT, OFLOW, G, E, L, ERR flags.
//   master = issue logic plus writeback consumer; slave = the ALU itself.
interface alu_pipe_if #(
    parameter int WIDTH   = 8,
    parameter int C_WIDTH = 4,
    parameter int TAG_W   = 4
);
    logic                 IN_VALID;
    logic                 IN_READY;
    logic                 MODE;
    logic [C_WIDTH-1:0]   CMD;
    logic [1:0]           OPV;
    logic [WIDTH-1:0]     OPA;
    logic [WIDTH-1:0]     OPB;
    logic                 CIN;
    logic [TAG_W-1:0]     IN_TAG;

    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [TAG_W-1:0]     OUT_TAG;
    logic [WIDTH:0]       RES;
    logic [2*WIDTH-1:0]   MUL_RES;
    logic                 COUT;
    logic                 OFLOW;
    logic                 G;
    logic                 E;
    logic                 L;
    logic                 ERR;

    modport master (
        output IN_VALID, MODE, CMD, OPV, OPA, OPB, CIN, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_TAG, RES, MUL_RES, COUT, OFLOW, G, E, L, ERR
    );

    modport slave (
        input  IN_VALID, MODE, CMD, OPV, OPA, OPB, CIN, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, OUT_TAG, RES, MUL_RES, COUT, OFLOW, G, E, L, ERR
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with in-order retirement and a multi-cycle multiply.
//   CLK  : rising-edge clock
//   RST  : synchronous active-high reset (clears state and all outputs)
//   CE   : clock enable; 0 freezes everything and drops IN_READY
//   bus  : alu_pipe_if slave modport (command in, result out)
// One operation is in flight at a time. Non-multiply results appear right after
// the accepting edge; MUL/MULSH hold IN_READY low for MUL_LAT-1 cycles first.
module alu_pipe #(
    parameter int WIDTH   = 8,
    parameter int C_WIDTH = 4,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      CE,
    alu_pipe_if.slave bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic [WIDTH:0]          a_x, b_x, cin_x, one_x;
    logic signed [WIDTH-1:0] sa, sb;
    logic [SH_W-1:0]         amt;
    logic                    amt_bad;
    logic [PW-1:0]           rot2;

    logic [WIDTH:0]          res_c;
    logic [PW-1:0]           mul_c;
    logic [WIDTH-1:0]        lr;
    logic                    cout_c, oflow_c, g_c, e_c, l_c, err_c;
    logic                    is_mul_c, arith_c, undef_c, rot_c;
    logic [1:0]              need_c;
    int unsigned             op;

    // Operands widened by one bit so the top bit of every sum/difference is
    // the carry or borrow.
    assign a_x     = {1'b0, bus.OPA};
    assign b_x     = {1'b0, bus.OPB};
    assign cin_x   = {{WIDTH{1'b0}}, bus.CIN};
    assign one_x   = {{WIDTH{1'b0}}, 1'b1};
    assign sa      = signed'(bus.OPA);
    assign sb      = signed'(bus.OPB);
    assign amt     = bus.OPB[SH_W-1:0];
    assign amt_bad = (bus.OPB >> SH_W) != '0;

    // ---- stage p0: combinational decode and execute of the presented command
    always_comb begin
        res_c    = '0;
        mul_c    = '0;
        lr       = '0;
        rot2     = '0;
        cout_c   = 1'b0;
        oflow_c  = 1'b0;
        g_c      = 1'b0;
        e_c      = 1'b0;
        l_c      = 1'b0;
        is_mul_c = 1'b0;
        arith_c  = 1'b0;
        undef_c  = 1'b0;
        rot_c    = 1'b0;
        need_c   = 2'b11;
        op       = 32'(bus.CMD);
        if (bus.MODE) begin
            arith_c = 1'b1;
            case (op)
                0:  res_c = a_x + b_x;
                1:  res_c = a_x - b_x;
                2:  res_c = a_x + b_x + cin_x;
                3:  res_c = a_x - b_x - cin_x;
                4:  begin res_c = a_x + one_x; need_c = 2'b01; end
                5:  begin res_c = a_x - one_x; need_c = 2'b01; end
                6:  begin res_c = b_x + one_x; need_c = 2'b10; end
                7:  begin res_c = b_x - one_x; need_c = 2'b10; end
                8:  begin
                        arith_c = 1'b0;
                        g_c = bus.OPA > bus.OPB;
                        e_c = bus.OPA == bus.OPB;
                        l_c = bus.OPA < bus.OPB;
                    end
                9:  begin
                        arith_c  = 1'b0;
                        is_mul_c = 1'b1;
                        mul_c    = PW'(bus.OPA) * PW'(bus.OPB);
                    end
                10: begin
                        arith_c  = 1'b0;
                        is_mul_c = 1'b1;
                        mul_c    = (PW'(bus.OPA) << 1) * PW'(bus.OPB);
                    end
                11: begin
                        res_c   = a_x + b_x;
                        oflow_c = add_ovf(sa, sb, res_c[WIDTH-1:0]);
                    end
                12: begin
                        res_c   = a_x - b_x;
                        oflow_c = sub_ovf(sa, sb, res_c[WIDTH-1:0]);
                    end
                default: undef_c = 1'b1;
            endcase
            cout_c = arith_c & res_c[WIDTH];
        end else begin
            case (op)
                0:  lr = bus.OPA & bus.OPB;
                1:  lr = ~(bus.OPA & bus.OPB);
                2:  lr = bus.OPA | bus.OPB;
                3:  lr = ~(bus.OPA | bus.OPB);
                4:  lr = bus.OPA ^ bus.OPB;
                5:  lr = ~(bus.OPA ^ bus.OPB);
                6:  begin lr = ~bus.OPA;     need_c = 2'b01; end
                7:  begin lr = ~bus.OPB;     need_c = 2'b10; end
                8:  begin lr = bus.OPA >> 1; need_c = 2'b01; end
                9:  begin lr = bus.OPA << 1; need_c = 2'b01; end
                10: begin lr = bus.OPB >> 1; need_c = 2'b10; end
                11: begin lr = bus.OPB << 1; need_c = 2'b10; end
                // Rotates shift a doubled copy of OPA and take one half.
                12: begin
                        rot_c = 1'b1;
                        rot2  = {bus.OPA, bus.OPA} << amt;
                        lr    = rot2[PW-1:WIDTH];
                    end
                13: begin
                        rot_c = 1'b1;
                        rot2  = {bus.OPA, bus.OPA} >> amt;
                        lr    = rot2[WIDTH-1:0];
                    end
                default: undef_c = 1'b1;
            endcase
            res_c = {1'b0, lr};
        end

        err_c = undef_c | ((need_c & ~bus.OPV) != 2'b00) | (rot_c & amt_bad);
        if (err_c) begin
            res_c    = '0;
            mul_c    = '0;
            cout_c   = 1'b0;
            oflow_c  = 1'b0;
            g_c      = 1'b0;
            e_c      = 1'b0;
            l_c      = 1'b0;
            is_mul_c = 1'b0;
        end
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               vld_p1;
    logic [TAG_W-1:0]   tag_p1;
    logic [WIDTH:0]     res_p1;
    logic [PW-1:0]      mul_p1;
    logic               cout_p1, oflow_p1, g_p1, e_p1, l_p1, err_p1;
    logic               in_ready;
    logic               accept;

    // In OUT a new command is only taken when the current result retires on
    // the same edge, which keeps results in acceptance order.
    assign in_ready = !RST && CE &&
                      ((state == S_IDLE) || ((state == S_OUT) && bus.OUT_READY));
    assign accept   = in_ready && bus.IN_VALID;

    // ---- stage p1: registered result, control FSM and multiply countdown
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            vld_p1   <= 1'b0;
            tag_p1   <= '0;
            res_p1   <= '0;
            mul_p1   <= '0;
            cout_p1  <= 1'b0;
            oflow_p1 <= 1'b0;
            g_p1     <= 1'b0;
            e_p1     <= 1'b0;
            l_p1     <= 1'b0;
            err_p1   <= 1'b0;
        end else if (CE) begin
            if (accept) begin
                // The product is computed from operands sampled here; the MUL
                // state only models the latency before it is presented.
                tag_p1   <= bus.IN_TAG;
                res_p1   <= res_c;
                mul_p1   <= mul_c;
                cout_p1  <= cout_c;
                oflow_p1 <= oflow_c;
                g_p1     <= g_c;
                e_p1     <= e_c;
                l_p1     <= l_c;
                err_p1   <= err_c;
                if (is_mul_c && (MUL_LAT > 1)) begin
                    state  <= S_MUL;
                    cnt    <= CNT_W'(MUL_LAT - 1);
                    vld_p1 <= 1'b0;
                end else begin
                    state  <= S_OUT;
                    vld_p1 <= 1'b1;
                end
            end else if ((state == S_OUT) && bus.OUT_READY) begin
                state  <= S_IDLE;
                vld_p1 <= 1'b0;
            end else if (state == S_MUL) begin
                // The edge that takes cnt from 1 to 0 is the one that presents
                // the product, giving MUL_LAT-1 busy cycles after acceptance.
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state  <= S_OUT;
                    vld_p1 <= 1'b1;
                end
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = vld_p1;
    assign bus.OUT_TAG   = tag_p1;
    assign bus.RES       = res_p1;
    assign bus.MUL_RES   = mul_p1;
    assign bus.COUT      = cout_p1;
    assign bus.OFLOW     = oflow_p1;
    assign bus.G         = g_p1;
    assign bus.E         = e_p1;
    assign bus.L         = l_p1;
    assign bus.ERR       = err_p1;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8, MUL_LAT=3).
// The driver pushes the reference result of every accepted command; a monitor
// pops and compares on each output handshake.
module tb_alu_pipe;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int ML = 3;
    localparam int TW = 4;

    typedef struct packed {
        logic [3:0]  tag;
        logic [8:0]  res;
        logic [15:0] mul;
        logic        cout;
        logic        oflow;
        logic        g;
        logic        e;
        logic        l;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W), .C_WIDTH(CW), .TAG_W(TW)) bus ();

    alu_pipe #(.WIDTH(W), .C_WIDTH(CW), .MUL_LAT(ML), .TAG_W(TW)) dut (
        .CLK (clk),
        .RST (rst),
        .CE  (ce),
        .bus (bus)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];
    bit   rand_bp = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, want);
    endtask

    function automatic exp_t outvec();
        exp_t v;
        v = {bus.OUT_TAG, bus.RES, bus.MUL_RES, bus.COUT, bus.OFLOW,
             bus.G, bus.E, bus.L, bus.ERR};
        return v;
    endfunction

    // Reference model: integer arithmetic straight from the operation table.
    function automatic exp_t model(input bit mode, input int cmd, input bit [1:0] opv,
                                   input int a, input int b, input bit cin,
                                   input bit [3:0] tag);
        exp_t x;
        int r, c, sa, sbv, s;
        bit [1:0] need;
        bit bad;
        x = '0; x.tag = tag; need = 2'b11; bad = 1'b0; r = 0; c = int'(cin);
        sa  = (a >= 128) ? a - 256 : a;
        sbv = (b >= 128) ? b - 256 : b;
        if (mode) begin
            case (cmd)
                0: r = a + b;
                1: r = a - b;
                2: r = a + b + c;
                3: r = a - b - c;
                4: begin r = a + 1; need = 2'b01; end
                5: begin r = a - 1; need = 2'b01; end
                6: begin r = b + 1; need = 2'b10; end
                7: begin r = b - 1; need = 2'b10; end
                8: begin x.g = (a > b); x.e = (a == b); x.l = (a < b); end
                9: x.mul = 16'(a * b);
                10: x.mul = 16'((2 * a * b) % 65536);
                11: begin r = a + b; s = sa + sbv; x.oflow = (s > 127) || (s < -128); end
                12: begin r = a - b; s = sa - sbv; x.oflow = (s > 127) || (s < -128); end
                default: bad = 1'b1;
            endcase
            // Low 9 bits of the true result: bit 8 is the carry, or the
            // borrow when the true difference is negative.
            if (cmd <= 7 || cmd == 11 || cmd == 12) begin
                x.res  = 9'(r & 511);
                x.cout = x.res[8];
            end
        end else begin
            case (cmd)
                0: r = a & b;
                1: r = 255 - (a & b);
                2: r = a | b;
                3: r = 255 - (a | b);
                4: r = a ^ b;
                5: r = 255 - (a ^ b);
                6: begin r = 255 - a; need = 2'b01; end
                7: begin r = 255 - b; need = 2'b10; end
                8: begin r = a / 2; need = 2'b01; end
                9: begin r = (a * 2) % 256; need = 2'b01; end
                10: begin r = b / 2; need = 2'b10; end
                11: begin r = (b * 2) % 256; need = 2'b10; end
                12: begin
                        if (b >= 8) bad = 1'b1;
                        else begin
                            r = a;
                            for (int i = 0; i < b; i++) r = ((r * 2) % 256) + r / 128;
                        end
                    end
                13: begin
                        if (b >= 8) bad = 1'b1;
                        else begin
                            r = a;
                            for (int i = 0; i < b; i++) r = r / 2 + (r % 2) * 128;
                        end
                    end
                default: bad = 1'b1;
            endcase
            x.res = 9'(r);
        end
        if (bad || ((need & ~opv) != 2'b00)) begin
            x = '0;
            x.tag = tag;
            x.err = 1'b1;
        end
        return x;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input bit mode, input int cmd, input bit [1:0] opv,
                         input int a, input int b, input bit cin,
                         input bit [3:0] tag, output int waits);
        exp_t x;
        bit mulp;
        x    = model(mode, cmd, opv, a, b, cin, tag);
        mulp = mode && (cmd == 9 || cmd == 10) && !x.err;
        bus.MODE = mode; bus.CMD = 4'(cmd); bus.OPV = opv;
        bus.OPA = 8'(a); bus.OPB = 8'(b); bus.CIN = cin; bus.IN_TAG = tag;
        bus.IN_VALID = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.IN_READY) begin
            waits++;
            if (waits > 500) begin
                $display("FAIL accept_timeout: IN_READY low for %0d cycles, required <= 500", waits);
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
        end
        sb.push_back(x);
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        bus.OPA = 8'($urandom_range(0, 255));
        bus.OPB = 8'($urandom_range(0, 255));
        check("post_accept_valid", 64'(bus.OUT_VALID), 64'(!mulp));
    endtask

    // Counts negedges with OUT_VALID low, then resyncs to posedge+1.
    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.OUT_VALID) begin
            n++;
            if (n > 50) begin
                $display("FAIL valid_timeout: OUT_VALID low for %0d cycles, required <= 50", n);
                $fatal(1, "valid timeout");
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ce && bus.OUT_VALID && bus.OUT_READY) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: tag %0d presented, required no result pending",
                         bus.OUT_TAG);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("result", 64'(outvec()), 64'(x));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bus.OUT_READY = ($urandom_range(0, 3) != 0);
            ce            = ($urandom_range(0, 7) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w, n;
        exp_t snap;
        bit   mode;
        int   cmd, a, b;
        bit [1:0] opv;

        bus.IN_VALID = 1'b1; bus.MODE = 1'b1; bus.CMD = '0; bus.OPV = 2'b11;
        bus.OPA = 8'h12; bus.OPB = 8'h34; bus.CIN = 1'b0; bus.IN_TAG = 4'h7;
        bus.OUT_READY = 1'b1;

        // Reset held for two edges with a command offered.
        repeat (2) begin
            @(negedge clk);
            check("reset_in_ready", 64'(bus.IN_READY), 64'(0));
            check("reset_outputs", 64'({bus.OUT_VALID, outvec()}), 64'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.IN_VALID = 1'b0;

        // Directed arithmetic, logic, rotate and error cases.
        issue(1, 0,  2'b11, 'h0F, 'h02, 0, 1, w);
        issue(1, 2,  2'b11, 'hFF, 'h00, 1, 2, w);
        issue(1, 1,  2'b11, 'h02, 'h0F, 0, 3, w);
        issue(1, 12, 2'b11, 'h57, 'hAA, 0, 4, w);
        issue(1, 11, 2'b11, 'hF1, 'hF1, 0, 7, w);
        issue(1, 9,  2'b11, 'h0F, 'h02, 0, 5, w);
        issue(0, 0,  2'b11, 'h3C, 'h0F, 0, 6, w);
        check("mul_in_ready_low_cycles", 64'(w), 64'(ML - 1));
        issue(0, 12, 2'b11, 'h0F, 'h02, 0, 8, w);
        issue(0, 12, 2'b11, 'h0F, 'h82, 0, 9, w);
        issue(1, 0,  2'b01, 'h01, 'h01, 0, 10, w);
        issue(1, 14, 2'b11, 'h01, 'h01, 0, 11, w);
        issue(1, 8,  2'b11, 'h05, 'h09, 0, 12, w);
        issue(0, 13, 2'b11, 'h81, 'h01, 0, 13, w);
        issue(1, 9,  2'b11, 'h0F, 'h02, 1, 14, w);
        issue(1, 10, 2'b11, 'h81, 'h03, 0, 15, w);
        wait_valid(n);
        check("mul_latency", 64'(n), 64'(ML - 1));

        // Backpressure: result held and input blocked for two cycles.
        issue(0, 4, 2'b11, 'h3C, 'h0F, 0, 1, w);
        bus.OUT_READY = 1'b0;
        bus.MODE = 1'b0; bus.CMD = 4'd2; bus.OPV = 2'b11; bus.IN_VALID = 1'b1;
        @(negedge clk);
        snap = outvec();
        check("bp_in_ready_1", 64'(bus.IN_READY), 64'(0));
        check("bp_valid_held", 64'(bus.OUT_VALID), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_outputs_stable", 64'(outvec()), 64'(snap));
        check("bp_in_ready_2", 64'(bus.IN_READY), 64'(0));
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b1;

        // Stream of four logic ops: one accept per cycle.
        for (int i = 0; i < 4; i++) begin
            issue(0, $urandom_range(0, 5), 2'b11, $urandom_range(0, 255),
                  $urandom_range(0, 255), 0, 4'(2 + i), w);
            check("stream_no_stall", 64'(w), 64'(0));
        end

        // CE low for one cycle during a multiply delays it by one cycle.
        issue(1, 9, 2'b11, 'hA5, 'h3C, 0, 3, w);
        ce = 1'b0;
        @(negedge clk);
        check("ce_in_ready", 64'(bus.IN_READY), 64'(0));
        check("ce_no_valid", 64'(bus.OUT_VALID), 64'(0));
        @(posedge clk); #1;
        ce = 1'b1;
        wait_valid(n);
        check("ce_mul_delay", 64'(n + 1), 64'(ML));

        // Reset during a multiply discards it.
        issue(1, 9, 2'b11, 'h07, 'h09, 0, 4, w);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_mul_in_ready", 64'(bus.IN_READY), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        check("rst_mid_mul_idle", 64'(bus.IN_READY), 64'(1));
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_mul_no_valid", 64'(bus.OUT_VALID), 64'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;

        // Randomized traffic with random CE and OUT_READY.
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            mode = 1'($urandom_range(0, 1));
            cmd  = $urandom_range(0, 15);
            opv  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            a    = $urandom_range(0, 255);
            if (!mode && cmd >= 12 && $urandom_range(0, 3) != 0) b = $urandom_range(0, 7);
            else b = $urandom_range(0, 255);
            issue(mode, cmd, opv, a, b, 1'($urandom_range(0, 1)), 4'(i), w);
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        ce = 1'b1;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
